// File: rtl/seq_shift_add_mult_if.sv
// rtl/seq_shift_add_mult_if.sv - operand/result handshake bundle for seq_shift_add_mult
//
// Purpose: groups the operand-side and result-side handshake signals of the
// sequential multiplier.
// Signals:
//   in_valid, in_ready   operand handshake
//   a, b, signed_mode    operands and per-operation signedness
//   out_valid, out_ready result handshake
//   p                    2*WIDTH-bit product
//   busy                 multiplier is in CALC or DONE
// Modports:
//   master - operand source / result consumer side
//   slave  - multiplier side
interface seq_shift_add_mult_if #(
    parameter int WIDTH = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 signed_mode;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   p;
    logic                 busy;

    modport master (
        output in_valid, a, b, signed_mode, out_ready,
        input  in_ready, out_valid, p, busy
    );

    modport slave (
        input  in_valid, a, b, signed_mode, out_ready,
        output in_ready, out_valid, p, busy
    );
endinterface

// File: rtl/seq_shift_add_mult.sv
// rtl/seq_shift_add_mult.sv - sequential shift-and-add multiplier, signed/unsigned, valid/ready
//
// Purpose: multiplies two WIDTH-bit operands, retiring one multiplier bit per
// clock through a single 2*WIDTH-bit adder. Signed operands are converted to
// magnitudes on accept and the sign is reapplied when the result is loaded.
// Ports:
//   clk    system clock, rising edge
//   rst_n  synchronous active-low reset
//   bus    seq_shift_add_mult_if.slave (operand and result handshakes, busy)
module seq_shift_add_mult #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seq_shift_add_mult_if.slave  bus
);
    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [PW-1:0]    r_mcand;      // multiplicand magnitude, pre-shifted by count
    logic [WIDTH-1:0] r_mplier;     // multiplier magnitude, bit[count] sits at bit 0
    logic [PW-1:0]    r_acc;
    logic [CNT_W-1:0] r_count;
    logic             r_neg;
    logic [PW-1:0]    r_p;
    logic             r_out_valid;

    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [PW-1:0]    w_addend;
    logic [PW-1:0]    w_sum;
    logic [PW-1:0]    w_result;
    logic             w_last;

    // Two's-complement negation in WIDTH bits maps the most negative value
    // onto 2^(WIDTH-1), which is exactly its magnitude read as unsigned.
    assign w_a_mag  = (bus.signed_mode && bus.a[WIDTH-1]) ? (~bus.a + WIDTH'(1)) : bus.a;
    assign w_b_mag  = (bus.signed_mode && bus.b[WIDTH-1]) ? (~bus.b + WIDTH'(1)) : bus.b;

    // Shifting the operands instead of indexing by count keeps the datapath
    // to one adder with no barrel shifter or bit-select mux.
    assign w_addend = r_mplier[0] ? r_mcand : '0;
    assign w_sum    = r_acc + w_addend;
    assign w_result = r_neg ? (~w_sum + PW'(1)) : w_sum;
    assign w_last   = (r_count == LAST_BIT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_acc       <= '0;
            r_count     <= '0;
            r_neg       <= 1'b0;
            r_p         <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
                        r_mplier <= w_b_mag;
                        r_neg    <= bus.signed_mode & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        r_acc    <= '0;
                        r_count  <= '0;
                        r_state  <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    r_acc    <= w_sum;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_count  <= r_count + CNT_W'(1);
                    if (w_last) begin
                        r_p         <= w_result;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // p is left untouched on release so the consumer can
                    // still read it after the handshake.
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = (r_state == ST_IDLE);
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.out_valid = r_out_valid;
    assign bus.p         = r_p;
endmodule

// File: tb/tb_seq_shift_add_mult.sv
// tb/tb_seq_shift_add_mult.sv - scoreboard testbench for seq_shift_add_mult at WIDTH 4 and 8
module tb_seq_shift_add_mult;
    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_shift_add_mult_if #(.WIDTH(4)) if4 ();
    seq_shift_add_mult_if #(.WIDTH(8)) if8 ();

    seq_shift_add_mult #(.WIDTH(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
    seq_shift_add_mult #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));

    logic [7:0]  q4[$];
    logic [15:0] q8[$];
    int   acc4 = 0, acc8 = 0, prev_acc4 = 0;
    bit   have_prev4 = 0, chk_space4 = 0;
    bit   ov4 = 0, ov8 = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref4(input logic [3:0] x, input logic [3:0] y, input logic m);
        int sx, sy;
        sx = m ? int'($signed(x)) : int'(x);
        sy = m ? int'($signed(y)) : int'(y);
        return 8'(sx * sy);
    endfunction

    function automatic logic [15:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic m);
        int sx, sy;
        sx = m ? int'($signed(x)) : int'(x);
        sy = m ? int'($signed(y)) : int'(y);
        return 16'(sx * sy);
    endfunction

    // Scoreboard: push on the accept edge, pop on the result handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            ov4 = 1'b0;
            ov8 = 1'b0;
        end else begin
            if (if4.in_valid && if4.in_ready) begin
                q4.push_back(ref4(if4.a, if4.b, if4.signed_mode));
                if (chk_space4 && have_prev4) check("spacing4", 64'(cyc - prev_acc4), 64'd6);
                prev_acc4 = cyc;
                have_prev4 = 1'b1;
                acc4 = cyc;
            end
            if (if4.out_valid && !ov4) check("latency4", 64'(cyc - acc4), 64'd5);
            if (if4.out_valid && if4.out_ready) begin
                if (q4.size() == 0) check("sb_empty4", 64'(q4.size()), 64'd1);
                else check("p4", 64'(if4.p), 64'(q4.pop_front()));
            end
            ov4 = if4.out_valid;

            if (if8.in_valid && if8.in_ready) begin
                q8.push_back(ref8(if8.a, if8.b, if8.signed_mode));
                acc8 = cyc;
            end
            if (if8.out_valid && !ov8) check("latency8", 64'(cyc - acc8), 64'd9);
            if (if8.out_valid && if8.out_ready) begin
                if (q8.size() == 0) check("sb_empty8", 64'(q8.size()), 64'd1);
                else check("p8", 64'(if8.p), 64'(q8.pop_front()));
            end
            ov8 = if8.out_valid;
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accept edge.
    task automatic op4(input logic [3:0] ta, input logic [3:0] tb, input logic tm);
        int n;
        if4.in_valid = 1'b1;
        if4.a = ta;
        if4.b = tb;
        if4.signed_mode = tm;
        n = 0;
        @(negedge clk);
        while (!if4.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("accept_timeout4", 64'(n), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic tm);
        int n;
        if8.in_valid = 1'b1;
        if8.a = ta;
        if8.b = tb;
        if8.signed_mode = tm;
        n = 0;
        @(negedge clk);
        while (!if8.in_ready && n < 200) begin
            @(posedge clk);
            #1;
            if8.out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("accept_timeout8", 64'(n), 64'd0);
        @(posedge clk);
        #1;
        if8.out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_done4();
        int n;
        n = 0;
        while ((q4.size() != 0 || if4.busy) && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (n >= 200) check("drain4", 64'(q4.size()), 64'd0);
        #1;
    endtask

    task automatic wait_done8();
        int n;
        if8.out_ready = 1'b1;
        n = 0;
        while ((q8.size() != 0 || if8.busy) && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (n >= 200) check("drain8", 64'(q8.size()), 64'd0);
        #1;
    endtask

    logic [3:0] sa[4];
    logic [3:0] sb[4];
    logic [7:0] sp[4];

    initial begin
        int n;
        logic [7:0] v;
        sa = '{4'h8, 4'h8, 4'hF, 4'h0};
        sb = '{4'h8, 4'h7, 4'h1, 4'hB};
        sp = '{8'h40, 8'hC8, 8'hFF, 8'h00};

        rst_n = 1'b0;
        if4.in_valid = 1'b0; if4.a = '0; if4.b = '0; if4.signed_mode = 1'b0; if4.out_ready = 1'b1;
        if8.in_valid = 1'b0; if8.a = '0; if8.b = '0; if8.signed_mode = 1'b0; if8.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_ov4", 64'(if4.out_valid), 64'd0);
        check("rst_p4", 64'(if4.p), 64'd0);
        check("rst_rdy4", 64'(if4.in_ready), 64'd1);
        check("rst_busy4", 64'(if4.busy), 64'd0);
        check("rst_p8", 64'(if8.p), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset in the middle of CALC.
        op4(4'd5, 4'd3, 1'b0);
        if4.in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_ov", 64'(if4.out_valid), 64'd0);
        check("midrst_p", 64'(if4.p), 64'd0);
        check("midrst_rdy", 64'(if4.in_ready), 64'd1);
        check("midrst_busy", 64'(if4.busy), 64'd0);
        q4.delete();
        @(posedge clk);
        #1;
        op4(4'd2, 4'd3, 1'b0);
        if4.in_valid = 1'b0;
        wait_done4();
        check("after_rst_p", 64'(if4.p), 64'h06);

        // Unsigned exhaustive, back-to-back with in_valid held high.
        chk_space4 = 1'b1;
        have_prev4 = 1'b0;
        for (int i = 0; i < 256; i++) begin
            v = 8'(i);
            op4(v[7:4], v[3:0], 1'b0);
        end
        if4.in_valid = 1'b0;
        wait_done4();
        chk_space4 = 1'b0;
        check("exh_last_p", 64'(if4.p), 64'hE1);

        // Signed extremes.
        for (int i = 0; i < 4; i++) begin
            op4(sa[i], sb[i], 1'b1);
            if4.in_valid = 1'b0;
            wait_done4();
            check("signed_tab", 64'(if4.p), 64'(sp[i]));
        end

        // Backpressure: hold the result for 10 cycles with ignored in_valid pulses.
        if4.out_ready = 1'b0;
        op4(4'd9, 4'd7, 1'b0);
        if4.in_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!if4.out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("bp_wait", 64'(n), 64'd0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if4.in_valid = 1'b1;
            if4.a = 4'($urandom);
            if4.b = 4'($urandom);
            @(negedge clk);
            check("bp_ov", 64'(if4.out_valid), 64'd1);
            check("bp_p", 64'(if4.p), 64'd63);
            check("bp_rdy", 64'(if4.in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        if4.in_valid = 1'b0;
        if4.out_ready = 1'b1;
        @(posedge clk);
        #1;
        if4.out_ready = 1'b0;
        @(negedge clk);
        check("bp_rel_ov", 64'(if4.out_valid), 64'd0);
        check("bp_rel_rdy", 64'(if4.in_ready), 64'd1);
        check("bp_rel_p", 64'(if4.p), 64'd63);
        @(posedge clk);
        #1;
        if4.out_ready = 1'b1;

        // Operands scrambled during CALC must not affect the result.
        op4(4'hD, 4'h6, 1'b1);
        if4.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if4.a = 4'($urandom);
            if4.b = 4'($urandom);
            if4.signed_mode = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        wait_done4();
        check("hold_p", 64'(if4.p), 64'hEE);

        // WIDTH 8: extremes, then random with random backpressure.
        op8(8'h80, 8'h80, 1'b1);
        if8.in_valid = 1'b0;
        wait_done8();
        check("w8_smin", 64'(if8.p), 64'h4000);
        op8(8'hFF, 8'hFF, 1'b0);
        if8.in_valid = 1'b0;
        wait_done8();
        check("w8_umax", 64'(if8.p), 64'hFE01);
        for (int i = 0; i < 1000; i++) begin
            op8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
        end
        if8.in_valid = 1'b0;
        wait_done8();
        check("w8_sb_empty", 64'(q8.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
